// File: rtl/pc_bpred_unit.sv
// Fetch-stage PC register with a direct-mapped BTB and 2-bit direction counters.
// Predicts the next fetch address each cycle; execute-stage redirects and branch resolutions feed back in.
module pc_bpred_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(32'h8000_0000),
    parameter int unsigned     BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_F,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc_F,
    output logic [XLEN-1:0] pc_next,
    output logic            pred_taken_F,
    output logic [XLEN-1:0] pred_target_F
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

    logic [XLEN-1:0]                 r_pc;
    logic [BTB_ENTRIES-1:0]          r_valid;
    logic [BTB_ENTRIES-1:0][1:0]     r_ctr;
    logic [TAG_W-1:0]                r_tag [BTB_ENTRIES];
    logic [XLEN-1:0]                 r_tgt [BTB_ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic [1:0]       w_u_ctr;
    logic [1:0]       w_ctr_inc;
    logic [1:0]       w_ctr_dec;

    // Fetch-side lookup
    assign w_idx         = r_pc[IDX_W+1:2];
    assign w_tag         = r_pc[XLEN-1:IDX_W+2];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign pred_taken_F  = w_hit && r_ctr[w_idx][1];
    assign pred_target_F = r_tgt[w_idx];
    assign pc_F          = r_pc;

    // Redirect beats stall so a flush is never lost
    always_comb begin
        pc_next = r_pc + XLEN'(4);
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (stall_F) begin
            pc_next = r_pc;
        end else if (pred_taken_F) begin
            pc_next = pred_target_F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= pc_next;
        end
    end

    // Resolution-side lookup; reads old contents, no bypass into fetch
    assign w_u_idx   = upd_pc[IDX_W+1:2];
    assign w_u_tag   = upd_pc[XLEN-1:IDX_W+2];
    assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_u_ctr   = r_ctr[w_u_idx];
    assign w_ctr_inc = (w_u_ctr == 2'b11) ? 2'b11 : w_u_ctr + 2'd1;
    assign w_ctr_dec = (w_u_ctr == 2'b00) ? 2'b00 : w_u_ctr - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_ctr   <= {BTB_ENTRIES{2'b01}};
        end else if (upd_valid) begin
            if (w_u_hit) begin
                r_ctr[w_u_idx] <= upd_taken ? w_ctr_inc : w_ctr_dec;
            end else if (upd_taken) begin
                r_valid[w_u_idx] <= 1'b1;
                r_ctr[w_u_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target storage needs no reset; a taken update always leaves the tag equal to upd_pc's
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            r_tag[w_u_idx] <= w_u_tag;
            r_tgt[w_u_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_pc_bpred_unit.sv
// Bench for pc_bpred_unit: directed scenarios then random traffic, checked against a table-based model.
module tb_pc_bpred_unit;

    localparam int unsigned N = 16;
    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, stall_F, redirect_valid, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [31:0] pc_F, pc_next, pred_target_F;
    logic        pred_taken_F;

    int checks = 0;
    int errors = 0;

    // Model state: one record per BTB slot plus the fetch PC
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    bit          m_init = 0;

    pc_bpred_unit #(.XLEN(32), .RESET_VEC(RV), .BTB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .stall_F(stall_F),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .pc_F(pc_F), .pc_next(pc_next), .pred_taken_F(pred_taken_F), .pred_target_F(pred_target_F)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [31:0] tagof(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    // One clock: drive inputs, check the combinational prediction, clock, advance the model, check pc_F
    task automatic step(input bit r, input bit st, input bit rv, input logic [31:0] rpc,
                        input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
        bit          e_pt;
        logic [31:0] e_next;
        int          i, u;
        bit          uhit;
        rst = r; stall_F = st; redirect_valid = rv; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        #3;
        i      = slot(m_pc);
        e_pt   = m_valid[i] && (m_tag[i] == tagof(m_pc)) && (m_ctr[i] >= 2);
        e_next = rv ? rpc : st ? m_pc : e_pt ? m_tgt[i] : m_pc + 32'd4;
        if (m_init && !r) begin
            chk("pred_taken", 32'(pred_taken_F), 32'(e_pt));
            chk("pc_next", pc_next, e_next);
            if (e_pt) chk("pred_target", pred_target_F, m_tgt[i]);
        end
        @(posedge clk);
        if (r) begin
            m_init = 1;
            m_pc   = RV;
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
            end
        end else begin
            m_pc = e_next;
            if (uv) begin
                u    = slot(upc);
                uhit = m_valid[u] && (m_tag[u] == tagof(upc));
                if (uhit) begin
                    if (ut) begin
                        m_ctr[u] = (m_ctr[u] == 3) ? 3 : m_ctr[u] + 1;
                        m_tgt[u] = utgt;
                    end else begin
                        m_ctr[u] = (m_ctr[u] == 0) ? 0 : m_ctr[u] - 1;
                    end
                end else if (ut) begin
                    m_valid[u] = 1;
                    m_tag[u]   = tagof(upc);
                    m_tgt[u]   = utgt;
                    m_ctr[u]   = 2;
                end
            end
        end
        #1;
        if (m_init) chk("pc_F", pc_F, m_pc);
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] pc);
        step(0, 0, 1, pc, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic train(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
        step(0, 0, 0, 32'h0, 1, pc, t, tgt);
    endtask

    initial begin
        logic [31:0] rpc, upc, utgt;
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 0;
            m_ctr[k]   = 1;
            m_tag[k]   = '0;
            m_tgt[k]   = '0;
        end
        m_pc = '0;

        // Reset and sequential fetch
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        chk("reset_pc", pc_F, 32'h8000_0000);
        #3;
        chk("reset_pred", 32'(pred_taken_F), 32'd0);
        chk("reset_next", pc_next, 32'h8000_0004);
        #1;
        idle();
        chk("seq_4", pc_F, 32'h8000_0004);
        idle();
        chk("seq_8", pc_F, 32'h8000_0008);

        // Train then predict
        train(32'h8000_0010, 1, 32'h8000_0100);
        jump(32'h8000_0010);
        #3;
        chk("train_pred", 32'(pred_taken_F), 32'd1);
        #1;
        idle();
        chk("train_follow", pc_F, 32'h8000_0100);

        // Counter decay 2 -> 1 -> 0
        train(32'h8000_0010, 0, 32'h0);
        train(32'h8000_0010, 0, 32'h0);
        jump(32'h8000_0010);
        #3;
        chk("decay_pred", 32'(pred_taken_F), 32'd0);
        #1;
        idle();
        chk("decay_next", pc_F, 32'h8000_0014);

        // Redirect overrides stall; stall alone holds
        step(0, 1, 1, 32'h8000_0200, 0, 32'h0, 0, 32'h0);
        chk("redir_stall", pc_F, 32'h8000_0200);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
            chk("stall_hold", pc_F, 32'h8000_0200);
        end

        // Aliasing at idx 4
        train(32'h8000_0010, 1, 32'h8000_0300);
        train(32'h8000_0010, 1, 32'h8000_0300);
        jump(32'h8000_0050);
        #3;
        chk("alias_miss", 32'(pred_taken_F), 32'd0);
        #1;
        train(32'h8000_0050, 1, 32'h8000_0400);
        jump(32'h8000_0010);
        #3;
        chk("alias_evict", 32'(pred_taken_F), 32'd0);
        #1;
        jump(32'h8000_0050);
        #3;
        chk("alias_new", 32'(pred_taken_F), 32'd1);
        #1;

        // Wrap past the top of the address space
        jump(32'hFFFF_FFFC);
        chk("wrap_top", pc_F, 32'hFFFF_FFFC);
        idle();
        chk("wrap_zero", pc_F, 32'h0000_0000);

        // Same-cycle update and lookup of the same slot sees old contents
        jump(32'h8000_0024);
        step(0, 0, 0, 32'h0, 1, 32'h8000_0024, 1, 32'h8000_0500);

        // Random traffic over a small, heavily aliased window
        for (int n = 0; n < 600; n++) begin
            rpc  = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 9) == 0) rpc = rpc | 32'($urandom_range(0, 3));
            upc  = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4;
            utgt = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4;
            step($urandom_range(0, 99) < 2, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, rpc,
                 $urandom_range(0, 1) == 1, upc, $urandom_range(0, 2) != 0, utgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
